// File: rtl/switch_int_ctrl.sv
// switch_int_ctrl
//   Debounces a bank of raw mechanical switch inputs, latches selected edge
//   events as pending interrupts and presents them one at a time to a CPU
//   through a request/acknowledge handshake. The lowest-numbered enabled
//   pending channel is serviced first.
//
// Parameters
//   N_IN       number of switch inputs (1..16)
//   DB_CYCLES  clocks a synchronised level must differ before it is accepted (1..255)
//   VEC_W      width of IntVector; 2**VEC_W must cover N_IN
//
// Ports
//   clk          system clock, all state on rising edge
//   Reset        asynchronous active-low reset
//   SwitchInput  raw asynchronous switch levels
//   MaskWrite    load strobe for the interrupt mask
//   MaskData     mask value, 1 enables a channel's interrupt
//   EdgeSel      per-channel edge select, 1 = rising, 0 = falling
//   IntAck       CPU acknowledge (level)
//   SwitchState  debounced switch levels
//   Pending      latched edge events
//   IntReq       registered interrupt request
//   IntVector    index of the channel being serviced
module switch_int_ctrl #(
  parameter int unsigned N_IN      = 8,
  parameter int unsigned DB_CYCLES = 4,
  parameter int unsigned VEC_W     = 3
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [N_IN-1:0]  SwitchInput,
  input  logic             MaskWrite,
  input  logic [N_IN-1:0]  MaskData,
  input  logic [N_IN-1:0]  EdgeSel,
  input  logic             IntAck,
  output logic [N_IN-1:0]  SwitchState,
  output logic [N_IN-1:0]  Pending,
  output logic             IntReq,
  output logic [VEC_W-1:0] IntVector
);

  localparam int unsigned     CNT_W    = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_HOLD
  } state_e;

  logic [N_IN-1:0]            sync1_q, sync1_d;
  logic [N_IN-1:0]            sync2_q, sync2_d;
  logic [N_IN-1:0]            sw_q, sw_d;
  logic [N_IN-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [N_IN-1:0]            pend_q, pend_d;
  logic [N_IN-1:0]            mask_q, mask_d;
  state_e                     state_q, state_d;
  logic                       req_q, req_d;
  logic [VEC_W-1:0]           vec_q, vec_d;

  logic [N_IN-1:0]            pend_set;
  logic [N_IN-1:0]            pend_clr;
  logic [N_IN-1:0]            qual;
  logic                       any_qual;
  logic [VEC_W-1:0]           lowest_idx;

  // Two-flop synchroniser.
  always_comb begin
    sync1_d = SwitchInput;
    sync2_d = sync1_q;
  end

  // Debounce: count consecutive clocks the synchronised level disagrees with
  // the accepted level; accept on the DB_CYCLES-th disagreeing clock.
  // A transition raises a pending event when the new level equals EdgeSel
  // (new 1 with EdgeSel=1 is a rise, new 0 with EdgeSel=0 is a fall).
  always_comb begin
    sw_d     = sw_q;
    cnt_d    = '0;
    pend_set = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (sync2_q[i] != sw_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          sw_d[i] = sync2_q[i];
          if (sync2_q[i] == EdgeSel[i]) begin
            pend_set[i] = 1'b1;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Priority pick of the lowest enabled pending channel.
  always_comb begin
    qual       = pend_q & mask_q;
    any_qual   = 1'b0;
    lowest_idx = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (qual[i] && !any_qual) begin
        lowest_idx = VEC_W'(i);
        any_qual   = 1'b1;
      end
    end
  end

  // Service FSM. The vector is latched on entry to REQ so later mask writes
  // cannot retarget or withdraw an outstanding request.
  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    pend_clr = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (any_qual) begin
          state_d = ST_REQ;
          vec_d   = lowest_idx;
        end
      end
      ST_REQ: begin
        if (IntAck) begin
          for (int unsigned i = 0; i < N_IN; i++) begin
            if (vec_q == VEC_W'(i)) begin
              pend_clr[i] = 1'b1;
            end
          end
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!IntAck) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    req_d = (state_d == ST_REQ);
  end

  // A new event on the channel being acknowledged survives the clear.
  always_comb begin
    pend_d = (pend_q & ~pend_clr) | pend_set;
    mask_d = MaskWrite ? MaskData : mask_q;
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sw_q    <= '0;
      cnt_q   <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      vec_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      sw_q    <= sw_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      state_q <= state_d;
      req_q   <= req_d;
      vec_q   <= vec_d;
    end
  end

  assign SwitchState = sw_q;
  assign Pending     = pend_q;
  assign IntReq      = req_q;
  assign IntVector   = vec_q;

endmodule

// File: tb/tb_switch_int_ctrl.sv
// Self-checking bench for switch_int_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// window-based behavioural model.
module tb_switch_int_ctrl;

  localparam int unsigned N  = 8;
  localparam int unsigned DB = 4;
  localparam int unsigned VW = 3;

  logic          clk = 1'b0;
  logic          Reset = 1'b0;
  logic [N-1:0]  SwitchInput = '0;
  logic          MaskWrite = 1'b0;
  logic [N-1:0]  MaskData = '0;
  logic [N-1:0]  EdgeSel = '1;
  logic          IntAck = 1'b0;
  logic [N-1:0]  SwitchState;
  logic [N-1:0]  Pending;
  logic          IntReq;
  logic [VW-1:0] IntVector;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  switch_int_ctrl #(
    .N_IN      (N),
    .DB_CYCLES (DB),
    .VEC_W     (VW)
  ) dut (
    .clk         (clk),
    .Reset       (Reset),
    .SwitchInput (SwitchInput),
    .MaskWrite   (MaskWrite),
    .MaskData    (MaskData),
    .EdgeSel     (EdgeSel),
    .IntAck      (IntAck),
    .SwitchState (SwitchState),
    .Pending     (Pending),
    .IntReq      (IntReq),
    .IntVector   (IntVector)
  );

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  // hist[k] = raw input sampled k edges ago (k=0 is this edge). The level
  // seen by the debouncer at an edge is the sample from two edges earlier;
  // a level is accepted once DB consecutive such samples oppose the state.
  logic [N-1:0] hist [0:DB+1];
  logic [N-1:0] m_sw   = '0;
  logic [N-1:0] m_pend = '0;
  logic [N-1:0] m_mask = '0;
  int           m_mode = 0;   // 0 idle, 1 requesting, 2 waiting for ack release
  int           m_vec  = 0;

  task automatic model_step();
    logic [N-1:0] nsw, set_b, clr_b, qual;
    logic         opposed;
    int           lw;
    if (!Reset) begin
      for (int k = 0; k <= DB + 1; k++) hist[k] = '0;
      m_sw = '0; m_pend = '0; m_mask = '0; m_mode = 0; m_vec = 0;
      return;
    end
    for (int k = DB + 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = SwitchInput;
    nsw   = m_sw;
    set_b = '0;
    for (int b = 0; b < N; b++) begin
      opposed = 1'b1;
      for (int k = 2; k <= DB + 1; k++) begin
        if (hist[k][b] == m_sw[b]) opposed = 1'b0;
      end
      if (opposed) begin
        nsw[b] = ~m_sw[b];
        if (nsw[b] == EdgeSel[b]) set_b[b] = 1'b1;
      end
    end
    clr_b = '0;
    qual  = m_pend & m_mask;
    lw    = 0;
    for (int b = N - 1; b >= 0; b--) if (qual[b]) lw = b;
    case (m_mode)
      0: if (qual != '0) begin m_vec = lw; m_mode = 1; end
      1: if (IntAck) begin clr_b[m_vec] = 1'b1; m_mode = 2; end
      default: if (!IntAck) m_mode = 0;
    endcase
    m_pend = (m_pend & ~clr_b) | set_b;
    if (MaskWrite) m_mask = MaskData;
    m_sw = nsw;
  endtask

  always begin
    @(posedge clk);
    model_step();
    #1;
    check("cyc_SwitchState", 32'(SwitchState), 32'(m_sw));
    check("cyc_Pending",     32'(Pending),     32'(m_pend));
    check("cyc_IntReq",      32'(IntReq),      32'(m_mode == 1));
    check("cyc_IntVector",   32'(IntVector),   32'(m_vec));
  end

  // ---------------- stimulus helpers ----------------
  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_req(input string name);
    int n;
    n = 0;
    while (!IntReq && n < 30) begin
      after_edge();
      n++;
    end
    check(name, 32'(IntReq), 32'd1);
  endtask

  task automatic ack();
    @(negedge clk) IntAck = 1'b1;
    @(negedge clk) IntAck = 1'b0;
  endtask

  task automatic write_mask(input logic [N-1:0] m);
    @(negedge clk) begin MaskWrite = 1'b1; MaskData = m; end
    @(negedge clk) MaskWrite = 1'b0;
  endtask

  initial begin
    // reset state
    after_edge();
    check("rst_SwitchState", 32'(SwitchState), 32'h0);
    check("rst_Pending",     32'(Pending),     32'h0);
    check("rst_IntReq",      32'(IntReq),      32'h0);
    check("rst_IntVector",   32'(IntVector),   32'h0);
    @(negedge clk) Reset = 1'b1;
    write_mask(8'hFF);
    repeat (3) @(negedge clk);

    // single rising channel: accepted on the 6th edge, request on the 7th
    SwitchInput = 8'h04;
    repeat (5) after_edge();
    check("lat_before", 32'(SwitchState), 32'h00);
    after_edge();
    check("lat_state", 32'(SwitchState), 32'h04);
    check("lat_pend",  32'(Pending),     32'h04);
    check("lat_req0",  32'(IntReq),      32'h0);
    after_edge();
    check("lat_req1",  32'(IntReq),      32'h1);
    check("lat_vec",   32'(IntVector),   32'h2);
    @(negedge clk) IntAck = 1'b1;
    after_edge();
    check("ack_pend",  32'(Pending),     32'h00);
    check("ack_req",   32'(IntReq),      32'h0);
    @(negedge clk) IntAck = 1'b0;

    // short glitch rejected
    @(negedge clk) SwitchInput = 8'h00;
    repeat (10) @(negedge clk);
    SwitchInput = 8'h04;
    repeat (3) @(negedge clk);
    SwitchInput = 8'h00;
    repeat (10) @(negedge clk);
    check("glitch_state", 32'(SwitchState), 32'h00);
    check("glitch_pend",  32'(Pending),     32'h00);
    check("glitch_req",   32'(IntReq),      32'h0);

    // two simultaneous rises: lowest first
    SwitchInput = 8'h22;
    wait_req("prio_req1");
    check("prio_vec1", 32'(IntVector), 32'h1);
    ack();
    wait_req("prio_req2");
    check("prio_vec2", 32'(IntVector), 32'h5);
    ack();
    after_edge();
    check("prio_pend", 32'(Pending), 32'h00);

    // masked event persists, raised after unmask
    write_mask(8'h00);
    SwitchInput = 8'h2A;
    repeat (10) @(negedge clk);
    check("mask_pend", 32'(Pending), 32'h08);
    check("mask_req",  32'(IntReq),  32'h0);
    MaskWrite = 1'b1; MaskData = 8'h08;
    after_edge();
    check("unmask_req0", 32'(IntReq), 32'h0);
    @(negedge clk) MaskWrite = 1'b0;
    after_edge();
    check("unmask_req1", 32'(IntReq),    32'h1);
    check("unmask_vec",  32'(IntVector), 32'h3);
    write_mask(8'hFF);
    check("req_held_mask", 32'(IntReq), 32'h1);
    ack();

    // falling-edge channel
    @(negedge clk) EdgeSel = 8'hFE;
    SwitchInput = 8'h2B;
    repeat (10) @(negedge clk);
    check("fall_rise_pend", 32'(Pending), 32'h00);
    SwitchInput = 8'h2A;
    repeat (6) after_edge();
    check("fall_pend", 32'(Pending), 32'h01);
    wait_req("fall_req");
    check("fall_vec", 32'(IntVector), 32'h0);
    ack();

    // asynchronous reset during a request
    @(negedge clk) begin EdgeSel = 8'hFF; SwitchInput = 8'h2B; end
    wait_req("arst_req");
    @(posedge clk);
    #3 Reset = 1'b0;
    #1;
    check("arst_req0",   32'(IntReq),      32'h0);
    check("arst_pend",   32'(Pending),     32'h00);
    check("arst_state",  32'(SwitchState), 32'h00);
    check("arst_vec",    32'(IntVector),   32'h0);
    @(negedge clk) SwitchInput = 8'hFF;
    @(negedge clk) Reset = 1'b1;
    repeat (5) after_edge();
    check("rel_before", 32'(SwitchState), 32'h00);
    after_edge();
    check("rel_state", 32'(SwitchState), 32'hFF);
    check("rel_pend",  32'(Pending),     32'hFF);
    check("rel_req",   32'(IntReq),      32'h0);

    // randomized traffic against the model
    write_mask(8'hFF);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 9) == 0) SwitchInput[b] = ~SwitchInput[b];
      end
      MaskWrite = ($urandom_range(0, 15) == 0);
      MaskData  = N'($urandom);
      if ($urandom_range(0, 31) == 0) EdgeSel = N'($urandom);
      if (IntReq && $urandom_range(0, 2) == 0) IntAck = 1'b1;
      else if (IntAck && $urandom_range(0, 2) == 0) IntAck = 1'b0;
      else if (!IntReq && $urandom_range(0, 19) == 0) IntAck = 1'b1;
      Reset = ($urandom_range(0, 599) != 0);
    end
    @(negedge clk) begin Reset = 1'b1; IntAck = 1'b0; MaskWrite = 1'b0; end
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_int_ctrl.md
SWITCH_INT_CTRL -- requirements
Module: switch_int_ctrl

Interface
REQ-001 Parameter N_IN, default 8: number of switch inputs; 1..16.
REQ-002 Parameter DB_CYCLES, default 4: debounce stability count in clocks; 1..255.
REQ-003 Parameter VEC_W, default 3: vector width; 2^VEC_W SHALL be >= N_IN.
REQ-004 clk  in  1  single system clock; all state on rising edge.
REQ-005 Reset  in  1  asynchronous, active-low reset; assertion clears all state immediately, release synchronous to clk.
REQ-006 SwitchInput  in  N_IN  raw asynchronous switch levels.
REQ-007 MaskWrite  in  1  write strobe for mask register.
REQ-008 MaskData  in  N_IN  mask value; bit=1 enables that channel's interrupt.
REQ-009 EdgeSel  in  N_IN  per-bit edge mode; 1=rising, 0=falling.
REQ-010 IntAck  in  1  CPU acknowledge, level.
REQ-011 SwitchState  out  N_IN  debounced switch levels.
REQ-012 Pending  out  N_IN  latched edge events.
REQ-013 IntReq  out  1  interrupt request to CPU.
REQ-014 IntVector  out  VEC_W  index of channel being serviced.

Function
REQ-015 Each SwitchInput bit SHALL pass through a 2-flop synchroniser before use.
REQ-016 Per bit, a counter SHALL increment each clock synchronised value differs from SwitchState and clear to 0 when equal.
REQ-017 When counter == DB_CYCLES-1 and values still differ, SwitchState bit SHALL take the synchronised value on that edge and counter SHALL clear.
REQ-018 Latency: raw change held stable -> SwitchState change exactly 2+DB_CYCLES clocks later; glitches shorter than DB_CYCLES clocks SHALL not change SwitchState.
REQ-019 Pending bit SHALL set on the clock edge SwitchState makes the transition selected by EdgeSel (0->1 if 1, 1->0 if 0), regardless of mask.
REQ-020 Mask register SHALL load MaskData on clock edge with MaskWrite=1; effective from next cycle.
REQ-021 Controller FSM states: IDLE, REQ, HOLD.
REQ-022 IDLE: if (Pending & Mask) != 0, latch IntVector = lowest set index, go REQ; IntReq=0.
REQ-023 REQ: IntReq=1, IntVector constant; on IntAck=1 clear Pending[IntVector], go HOLD.
REQ-024 HOLD: IntReq=0; remain until IntAck=0, then IDLE.
REQ-025 IntReq SHALL be registered: rises one clock after IDLE sees qualifying pending bit.
REQ-026 Simultaneous set and clear of same Pending bit SHALL leave it set (set wins).
REQ-027 Mask changes while in REQ SHALL NOT withdraw request or change IntVector.
REQ-028 Pending bits for masked channels SHALL persist and raise IntReq when unmasked.
REQ-029 IntAck while in IDLE SHALL be ignored.
REQ-030 EdgeSel change SHALL affect only subsequent transitions; no pending set by the change itself.

Reset
REQ-031 On Reset=0: synchronisers, counters, SwitchState, Pending, mask = 0; FSM = IDLE; IntReq=0; IntVector=0.
REQ-032 Reset mid-request SHALL drop IntReq asynchronously and discard all pending events.
REQ-033 After release, inputs held high SHALL produce a debounced rising transition at 2+DB_CYCLES clocks and set Pending for rising-edge channels.

Verification
REQ-034 DB_CYCLES=4, mask=0xFF, EdgeSel=0xFF; SwitchInput bit2 0->1 held -> SwitchState[2]=1 and Pending=0x04 at 6th clock, IntReq=1 next clock, IntVector=2; IntAck pulse -> Pending=0x00, IntReq=0.
REQ-035 bit2 high glitch 3 clocks (DB_CYCLES=4) -> SwitchState, Pending, IntReq unchanged.
REQ-036 Bits 5 and 1 rise same cycle -> IntVector=1 first; after ack/release IntVector=5.
REQ-037 mask=0x00, bit3 rises -> Pending=0x08, IntReq=0; write mask=0x08 -> IntReq=1 two clocks later, IntVector=3.
REQ-038 EdgeSel[0]=0, bit0 1->0 -> Pending[0] set; 0->1 -> no pending.
REQ-039 Reset asserted while IntReq=1 -> all outputs 0 immediately, no clock required.
